// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single wide SRAM port.
// One line transfer at a time: IDLE grants, ACCESS waits for mem_done or timeout, DONE acks.
module sram_port_arbiter #(
    parameter int ADDR_SIZE_BITS = 24,
    parameter int DATA_BITS      = 1536,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_read_0,
    input  logic                      req_write_0,
    input  logic [ADDR_SIZE_BITS-1:0] req_addr_0,
    input  logic [DATA_BITS-1:0]      req_wdata_0,
    input  logic                      req_read_1,
    input  logic                      req_write_1,
    input  logic [ADDR_SIZE_BITS-1:0] req_addr_1,
    input  logic [DATA_BITS-1:0]      req_wdata_1,
    output logic                      ack_0,
    output logic                      ack_1,
    output logic                      err,
    output logic [DATA_BITS-1:0]      rdata,
    output logic                      rdata_valid,
    output logic                      owner,
    output logic                      busy,
    output logic                      mem_read_enable,
    output logic                      mem_write_enable,
    output logic [ADDR_SIZE_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0]      mem_write_data,
    input  logic [DATA_BITS-1:0]      mem_read_data,
    input  logic                      mem_done,
    output logic [1:0]                state_dbg
);

    // Handshake: a requester holds req_read/req_write, addr and wdata stable until its
    // one-cycle ack, then drops the request the following cycle; the memory sees one
    // enable held through ACCESS and answers with a single-cycle mem_done.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    logic                      prio;
    logic                      op_write;
    logic [7:0]                timer;

    logic                      req_0;
    logic                      req_1;
    logic                      grant_port;
    logic                      grant_write;
    logic [ADDR_SIZE_BITS-1:0] grant_addr;
    logic [DATA_BITS-1:0]      grant_wdata;

    always_comb begin
        req_0       = req_read_0 | req_write_0;
        req_1       = req_read_1 | req_write_1;
        // Single requester wins outright; on contention the prio pointer decides.
        grant_port  = (req_0 && req_1) ? prio : req_1;
        grant_write = grant_port ? req_write_1 : req_write_0;
        grant_addr  = grant_port ? req_addr_1 : req_addr_0;
        grant_wdata = grant_port ? req_wdata_1 : req_wdata_0;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            prio             <= 1'b0;
            op_write         <= 1'b0;
            timer            <= '0;
            ack_0            <= 1'b0;
            ack_1            <= 1'b0;
            err              <= 1'b0;
            rdata            <= '0;
            rdata_valid      <= 1'b0;
            owner            <= 1'b0;
            busy             <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
        end else begin
            ack_0       <= 1'b0;
            ack_1       <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        owner            <= grant_port;
                        op_write         <= grant_write;
                        mem_address      <= grant_addr;
                        mem_write_data   <= grant_write ? grant_wdata : '0;
                        mem_read_enable  <= ~grant_write;
                        mem_write_enable <= grant_write;
                        timer            <= '0;
                        busy             <= 1'b1;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_done takes precedence over a timeout landing in the same cycle.
                    if (mem_done || timer == TIMER_LAST) begin
                        if (mem_done && !op_write) begin
                            rdata <= mem_read_data;
                        end
                        mem_read_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                        ack_0            <= ~owner;
                        ack_1            <= owner;
                        rdata_valid      <= mem_done & ~op_write;
                        err              <= ~mem_done;
                        state            <= DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    prio  <= ~owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: memory-side and ack-side expectation queues,
// with a responder that answers each access after a programmable delay.
module tb_sram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 1536;
    localparam int T  = 8;
    localparam int W  = DW + 26;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_read_0 = 1'b0, req_write_0 = 1'b0;
    logic          req_read_1 = 1'b0, req_write_1 = 1'b0;
    logic [AW-1:0] req_addr_0 = '0, req_addr_1 = '0;
    logic [DW-1:0] req_wdata_0 = '0, req_wdata_1 = '0;
    logic          ack_0, ack_1, err, rdata_valid, owner, busy;
    logic [DW-1:0] rdata;
    logic          mem_read_enable, mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_done = 1'b0;
    logic [1:0]    state_dbg;

    sram_port_arbiter #(
        .ADDR_SIZE_BITS(AW),
        .DATA_BITS(DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_read_0(req_read_0), .req_write_0(req_write_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_read_1(req_read_1), .req_write_1(req_write_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .ack_0(ack_0), .ack_1(ack_1), .err(err),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .owner(owner), .busy(busy),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_done(mem_done),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0]  mem_q[$];
    logic [W-1:0]  ack_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            mem_delay = 1;
    logic          mem_hold = 1'b0;
    logic [DW-1:0] rd_line = '0;

    function automatic logic [95:0] fold(input logic [W-1:0] v);
        logic [95:0] f;
        f = '0;
        for (int i = 0; i < W; i++) f[i % 96] ^= v[i];
        return f;
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (96-bit fold)", tag, fold(got), fold(exp));
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Memory responder and output monitor
    int            cyc = 0;
    int            acc_cnt = 0;
    int            first_acc = 0;
    int            done_cyc = 0;
    logic [W-1:0]  cur_mem = '0;
    logic [W-1:0]  cur_ack = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            acc_cnt  = 0;
            mem_done = 1'b0;
        end else begin
            if (mem_read_enable || mem_write_enable) begin
                acc_cnt++;
                if (acc_cnt == 1) begin
                    first_acc = cyc;
                    if (mem_q.size() == 0) check_eq("mem_unexpected", W'(1'b1), W'(1'b0));
                    else cur_mem = mem_q.pop_front();
                end
                check_eq("mem_we", W'(mem_write_enable), W'(cur_mem[DW+25]));
                check_eq("mem_re", W'(mem_read_enable), W'(cur_mem[DW+24]));
                check_eq("mem_addr", W'(mem_address), W'(cur_mem[DW+23:DW]));
                check_eq("mem_wdata", W'(mem_write_data), W'(cur_mem[DW-1:0]));
                mem_done      = !mem_hold && acc_cnt == mem_delay;
                mem_read_data = rd_line;
                if (mem_done) done_cyc = cyc;
            end else begin
                acc_cnt  = 0;
                mem_done = 1'b0;
            end
            if ((rdata_valid || err) && !(ack_0 || ack_1))
                check_eq("stray_strobe", W'(1'b1), W'(1'b0));
            if (ack_0 || ack_1) begin
                if (ack_0 && ack_1) check_eq("double_ack", W'(1'b1), W'(1'b0));
                if (ack_q.size() == 0) begin
                    check_eq("unexpected_ack", W'(1'b1), W'(1'b0));
                end else begin
                    cur_ack = ack_q.pop_front();
                    check_eq("ack_port", W'(ack_1), W'(cur_ack[DW+2]));
                    check_eq("err", W'(err), W'(cur_ack[DW+1]));
                    check_eq("rdata_valid", W'(rdata_valid), W'(cur_ack[DW]));
                    if (cur_ack[DW]) check_eq("rdata", W'(rdata), W'(cur_ack[DW-1:0]));
                    if (cur_ack[DW+1]) check_eq("abort_latency", W'(cyc - first_acc), W'(T));
                    else check_eq("done_latency", W'(cyc - done_cyc), W'(1));
                end
            end
        end
    end

    // Driver tasks
    task automatic push_req(input logic p, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic exp_err);
        logic          exp_rv;
        logic [DW-1:0] exp_rd;
        exp_rv = !wr && !exp_err;
        exp_rd = exp_rv ? rd_line : '0;
        mem_q.push_back({wr, !wr, a, wr ? wd : {DW{1'b0}}});
        ack_q.push_back(W'({p, exp_err, exp_rv, exp_rd}));
        if (!p) begin
            req_read_0 = rd; req_write_0 = wr; req_addr_0 = a; req_wdata_0 = wd;
        end else begin
            req_read_1 = rd; req_write_1 = wr; req_addr_1 = a; req_wdata_1 = wd;
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            if (ack_0) begin req_read_0 = 1'b0; req_write_0 = 1'b0; end
            if (ack_1) begin req_read_1 = 1'b0; req_write_1 = 1'b0; end
            n++;
        end while ((req_read_0 || req_write_0 || req_read_1 || req_write_1 || busy) && n < budget);
        if (req_read_0 || req_write_0 || req_read_1 || req_write_1 || busy)
            check_eq("wait_budget", W'(1'b1), W'(1'b0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, W'({ack_0, ack_1, err, rdata_valid, owner, busy,
                          mem_read_enable, mem_write_enable, state_dbg}), W'(0));
        check_eq("rst_mem_addr", W'(mem_address), W'(0));
        check_eq("rst_mem_wdata", W'(mem_write_data), W'(0));
        check_eq("rst_rdata", W'(rdata), W'(0));
    endtask

    initial begin
        logic          p, wr;
        logic [DW-1:0] wd;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset_outputs");

        // Single read from port 0
        mem_delay = 2;
        rd_line   = {192{8'hA5}};
        push_req(1'b0, 1'b1, 1'b0, 24'h000040, '0, 1'b0);
        wait_quiet(40);

        // Single write from port 1
        mem_delay = 3;
        push_req(1'b1, 1'b0, 1'b1, 24'h123456, {DW{1'b1}}, 1'b0);
        wait_quiet(40);

        // Timeout on port 1, then a normal request
        mem_hold = 1'b1;
        push_req(1'b1, 1'b1, 1'b0, 24'h000777, '0, 1'b1);
        wait_quiet(60);
        mem_hold  = 1'b0;
        mem_delay = 1;
        rd_line   = rand_line();
        push_req(1'b0, 1'b1, 1'b0, 24'h0000AA, '0, 1'b0);
        wait_quiet(40);

        // mem_done on the last allowed cycle counts as success
        mem_delay = T;
        push_req(1'b0, 1'b0, 1'b1, 24'h00BEEF, rand_line(), 1'b0);
        wait_quiet(60);

        // Read and write together on one port: write wins
        mem_delay = 2;
        push_req(1'b0, 1'b1, 1'b1, 24'h0ABCDE, rand_line(), 1'b0);
        wait_quiet(40);

        // Random single transactions
        for (int i = 0; i < 6; i++) begin
            p         = 1'($urandom_range(0, 1));
            wr        = 1'($urandom_range(0, 1));
            wd        = rand_line();
            mem_delay = $urandom_range(1, T);
            rd_line   = rand_line();
            push_req(p, !wr, wr, 24'($urandom()), wd, 1'b0);
            wait_quiet(60);
        end

        // Reset in the middle of ACCESS
        mem_hold = 1'b1;
        mem_q.push_back({1'b0, 1'b1, 24'h000040, {DW{1'b0}}});
        req_read_0 = 1'b1; req_addr_0 = 24'h000040;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_eq("rst_async_re", W'(mem_read_enable), W'(1'b0));
        check_eq("rst_async_busy", W'(busy), W'(1'b0));
        req_read_0 = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        mem_hold = 1'b0;
        check_reset_outputs("reset_mid_outputs");
        repeat (4) @(negedge clk);
        check_eq("no_ack_after_rst", W'({ack_0, ack_1, busy}), W'(0));
        check_eq("mem_q_drained", W'(mem_q.size()), W'(0));

        // Contention from reset: 0 then 1 each round
        mem_delay = 1;
        for (int r = 0; r < 4; r++) begin
            rd_line = rand_line();
            push_req(1'b0, 1'b1, 1'b0, 24'(32'h100 + r), '0, 1'b0);
            push_req(1'b1, 1'b0, 1'b1, 24'(32'h200 + r), rand_line(), 1'b0);
            wait_quiet(60);
        end

        // After port 0 alone, contention favors port 1
        rd_line = rand_line();
        push_req(1'b0, 1'b1, 1'b0, 24'h000300, '0, 1'b0);
        wait_quiet(40);
        push_req(1'b1, 1'b0, 1'b1, 24'h000401, rand_line(), 1'b0);
        push_req(1'b0, 1'b0, 1'b1, 24'h000400, rand_line(), 1'b0);
        wait_quiet(60);

        repeat (3) @(negedge clk);
        check_eq("ack_q_empty", W'(ack_q.size()), W'(0));
        check_eq("mem_q_empty", W'(mem_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
